// File: rtl/mips_cpu_divider_if.sv
// Handshake and operand/result bundle between the MIPS control unit and
// the iterative HI/LO divider.
interface mips_cpu_divider_if;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;

    // Control unit side: issues requests, consumes results.
    modport master (
        output start, sign, dividend, divisor,
        input  quotient, remainder, busy, done
    );

    // Divider side: accepts requests, produces results.
    modport slave (
        input  start, sign, dividend, divisor,
        output quotient, remainder, busy, done
    );
endinterface

// File: rtl/mips_cpu_divider.sv
// Iterative 32-bit restoring divider for DIV/DIVU.
// The divider produces one quotient bit per clock. Operands are reduced to
// magnitudes at start. The result signs are fixed up in a final FIX cycle.
module mips_cpu_divider (
    input  logic             clk,
    input  logic             reset,
    mips_cpu_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] q_q, q_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        done_q, done_d;

    logic [33:0] shifted;
    logic [32:0] trial;
    logic        trial_ok;
    logic        dvnd_neg;
    logic        dvsr_neg;

    // The operands are negative only in signed mode with bit 31 set.
    // The shift-subtract step compares the shifted partial remainder
    // with the divisor magnitude.
    always_comb begin
        dvnd_neg = bus.sign & bus.dividend[31];
        dvsr_neg = bus.sign & bus.divisor[31];
        shifted  = {rem_q, q_q[31]};
        trial    = shifted[32:0] - {1'b0, dvsr_q};
        trial_ok = (shifted >= {2'b00, dvsr_q});
    end

    // This block computes the next state and the datapath updates for the IDLE/RUN/FIX sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        q_d         = q_q;
        dvsr_d      = dvsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        div_zero_d  = div_zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_d        = dvnd_neg ? (32'd0 - bus.dividend) : bus.dividend;
                    dvsr_d     = dvsr_neg ? (32'd0 - bus.divisor) : bus.divisor;
                    neg_quo_d  = bus.sign & (bus.dividend[31] ^ bus.divisor[31]);
                    neg_rem_d  = dvnd_neg;
                    div_zero_d = (bus.divisor == 32'd0);
                    rem_d      = 33'd0;
                    cnt_d      = 5'd0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                if (trial_ok) begin
                    rem_d = trial;
                    q_d   = {q_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[32:0];
                    q_d   = {q_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                // Divide by zero returns all ones regardless of the sign.
                // The remainder path already reproduces the dividend.
                if (div_zero_q) begin
                    quotient_d = 32'hFFFF_FFFF;
                end else begin
                    quotient_d = neg_quo_q ? (32'd0 - q_q) : q_q;
                end
                remainder_d = neg_rem_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
                done_d      = 1'b1;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // This block holds the state and datapath registers. Reset clears the
    // results and aborts any division in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            rem_q       <= 33'd0;
            q_q         <= 32'd0;
            dvsr_q      <= 32'd0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            quotient_q  <= 32'd0;
            remainder_q <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            dvsr_q      <= dvsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            div_zero_q  <= div_zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
        end
    end

    // This block drives the outputs. busy covers RUN and FIX, so done can only fire while idle.
    always_comb begin
        bus.quotient  = quotient_q;
        bus.remainder = remainder_q;
        bus.busy      = (state_q != IDLE);
        bus.done      = done_q;
    end

endmodule

// File: tb/tb_mips_cpu_divider.sv
// Testbench for mips_cpu_divider. It runs directed DIV/DIVU cases, handshake
// and reset scenarios, and a randomized regression against an arithmetic
// reference model.
module tb_mips_cpu_divider;

    logic clk;
    logic reset;
    int   assert_count;
    int   fail_count;

    mips_cpu_divider_if bus ();

    mips_cpu_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison goes through this task.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model built from plain SystemVerilog division. It also
    // covers the divide-by-zero and signed-overflow results.
    task automatic refDiv(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // This task presents a request. It is called at a falling edge.
    task automatic startOp(input logic s, input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.sign     = s;
        bus.dividend = a;
        bus.divisor  = b;
    endtask

    // This task waits for done. It is entered at the falling edge that follows the accepting
    // edge. It counts the edges until done and the cycles that busy was seen.
    task automatic waitDone(input string tag, output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (!bus.done && edges < 60) begin
            if (bus.busy) busy_cycles++;
            @(negedge clk);
            edges++;
        end
        if (!bus.done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // This task runs one operation. It checks the results, the latency and the busy
    // duration, and that done lasts only one cycle.
    task automatic applyStimulus(input string tag, input logic s, input logic [31:0] a,
                                 input logic [31:0] b);
        logic [31:0] eq, er;
        int edges, busy_cycles;
        @(negedge clk);
        startOp(s, a, b);
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(tag, edges, busy_cycles);
        refDiv(s, a, b, eq, er);
        checkOutput({tag, "_q"}, bus.quotient, eq);
        checkOutput({tag, "_r"}, bus.remainder, er);
        checkOutput({tag, "_latency"}, 32'(edges), 32'd33);
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'd33);
        checkOutput({tag, "_busy_in_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    endtask

    // This function picks random operands, biased toward the boundary values.
    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // This block checks the handshake invariant on every cycle: done never coincides with busy.
    always @(negedge clk) begin
        if (!reset && bus.done && bus.busy) begin
            checkOutput("done_with_busy", 32'd1, 32'd0);
        end
    end

    // This block is the main test sequence.
    initial begin
        logic [31:0] eq, er, a0, b0;
        int edges, busy_cycles, done_seen;

        assert_count = 0;
        fail_count   = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.sign     = 1'b0;
        bus.dividend = 32'd0;
        bus.divisor  = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_q", bus.quotient, 32'd0);
        checkOutput("reset_r", bus.remainder, 32'd0);
        reset = 1'b0;

        applyStimulus("divu_100_7", 1'b0, 32'd100, 32'd7);
        checkOutput("divu_100_7_q_const", bus.quotient, 32'd14);
        checkOutput("divu_100_7_r_const", bus.remainder, 32'd2);

        applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_m7_2_q_const", bus.quotient, 32'hFFFF_FFFD);
        checkOutput("div_m7_2_r_const", bus.remainder, 32'hFFFF_FFFF);
        applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        checkOutput("div_7_m2_q_const", bus.quotient, 32'hFFFF_FFFD);
        checkOutput("div_7_m2_r_const", bus.remainder, 32'd1);
        applyStimulus("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        checkOutput("div_m7_m2_q_const", bus.quotient, 32'd3);
        checkOutput("div_m7_m2_r_const", bus.remainder, 32'hFFFF_FFFF);

        applyStimulus("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
        applyStimulus("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div_ovf_q_const", bus.quotient, 32'h8000_0000);
        applyStimulus("divu_5_0", 1'b0, 32'd5, 32'd0);
        checkOutput("divu_5_0_q_const", bus.quotient, 32'hFFFF_FFFF);
        checkOutput("divu_5_0_r_const", bus.remainder, 32'd5);
        applyStimulus("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0);

        // Start is held high and the operands change while busy.
        @(negedge clk);
        a0 = 32'd1000;
        b0 = 32'd33;
        startOp(1'b0, a0, b0);
        edges = 0;
        @(negedge clk);
        while (!bus.done && edges < 60) begin
            bus.sign     = 1'($urandom);
            bus.dividend = $urandom;
            bus.divisor  = $urandom;
            @(negedge clk);
            edges++;
        end
        bus.start = 1'b0;
        if (!bus.done) checkOutput("held_timeout", 32'd0, 32'd1);
        refDiv(1'b0, a0, b0, eq, er);
        checkOutput("held_q", bus.quotient, eq);
        checkOutput("held_r", bus.remainder, er);
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done) done_seen++;
            if (bus.busy) done_seen++;
        end
        checkOutput("held_single_done", 32'(done_seen), 32'd0);

        // Start is asserted in the done cycle, so the two operations run back to back.
        @(negedge clk);
        startOp(1'b1, 32'hFFFF_FC18, 32'd7);
        @(negedge clk);
        bus.start = 1'b0;
        waitDone("b2b_first", edges, busy_cycles);
        refDiv(1'b1, 32'hFFFF_FC18, 32'd7, eq, er);
        checkOutput("b2b_first_q", bus.quotient, eq);
        checkOutput("b2b_first_r", bus.remainder, er);
        startOp(1'b0, 32'd12345, 32'd100);
        @(negedge clk);
        bus.start = 1'b0;
        waitDone("b2b_second", edges, busy_cycles);
        checkOutput("b2b_gap", 32'(edges + 1), 32'd34);
        refDiv(1'b0, 32'd12345, 32'd100, eq, er);
        checkOutput("b2b_second_q", bus.quotient, eq);
        checkOutput("b2b_second_r", bus.remainder, er);

        // Reset is asserted at iteration 10 of an operation.
        @(negedge clk);
        startOp(1'b0, 32'd999, 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_q", bus.quotient, 32'd0);
        checkOutput("midrst_r", bus.remainder, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        checkOutput("midrst_no_done", 32'(done_seen), 32'd0);
        applyStimulus("after_rst", 1'b1, 32'hFFFF_FF00, 32'd9);

        // Randomized regression against the reference model.
        for (int i = 0; i < 300; i++) begin
            applyStimulus("rand", 1'($urandom), pickOperand(), pickOperand());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
